// File: rtl/ysyx_22050039_arb_pkg.sv
// Shared types for the pmem arbiter: FSM state encoding and requester ids.
package ysyx_22050039_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE = 2'd0;
  localparam arb_state_t S_IF = 2'd1;
  localparam arb_state_t S_LS = 2'd2;
  localparam arb_state_t RESP = 2'd3;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

endpackage

// File: rtl/ysyx_22050039_arb_pick.sv
// Combinational winner select between IF and LS requesters.
// YSYX_22050039_ARB_RR_EN selects round-robin; otherwise LS has fixed priority.
module ysyx_22050039_arb_pick
  import ysyx_22050039_arb_pkg::*;
(
  input  logic i_if_req,
  input  logic i_ls_req,
`ifdef YSYX_22050039_ARB_RR_EN
  input  logic i_rr_last,
`endif
  output logic o_win_id,
  output logic o_win_vld
);

  assign o_win_vld = i_if_req | i_ls_req;

`ifdef YSYX_22050039_ARB_RR_EN
  // On a tie the requester that did not win last time goes first.
  always_comb begin
    o_win_id = REQ_IF;
    if (i_if_req && i_ls_req) begin
      o_win_id = (i_rr_last == REQ_IF) ? REQ_LS : REQ_IF;
    end else if (i_ls_req) begin
      o_win_id = REQ_LS;
    end
  end
`else
  assign o_win_id = i_ls_req ? REQ_LS : REQ_IF;
`endif

endmodule

// File: rtl/ysyx_22050039_mem_arbiter.sv
// Single-port pmem arbiter between instruction fetch and load/store.
// Build option: YSYX_22050039_ARB_RR_EN enables round-robin tie-breaking.
//
// state | meaning
// IDLE  | waiting for a request; grant pulses here
// S_IF  | IF access on the memory port, waiting for mem_done
// S_LS  | LS access on the memory port, waiting for mem_done
// RESP  | one-cycle rvalid to the granted requester
module ysyx_22050039_mem_arbiter #(
  parameter int XLEN   = 64,
  parameter int MASK_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_if_req,
  input  logic [XLEN-1:0]   i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [XLEN-1:0]   o_if_rdata,
  input  logic              i_ls_req,
  input  logic              i_ls_we,
  input  logic [XLEN-1:0]   i_ls_addr,
  input  logic [XLEN-1:0]   i_ls_wdata,
  input  logic [MASK_W-1:0] i_ls_wmask,
  output logic              o_ls_gnt,
  output logic              o_ls_rvalid,
  output logic [XLEN-1:0]   o_ls_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [MASK_W-1:0] o_mem_wmask,
  input  logic              i_mem_done,
  input  logic [XLEN-1:0]   i_mem_rdata,
  output logic              o_busy
);
  import ysyx_22050039_arb_pkg::*;

  arb_state_t        r_state;
  logic              r_owner;
  logic              r_we;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [MASK_W-1:0] r_wmask;
  logic [XLEN-1:0]   r_if_rdata;
  logic [XLEN-1:0]   r_ls_rdata;

  logic w_win_id;
  logic w_win_vld;
  logic w_grant;
  logic w_in_mem;

`ifdef YSYX_22050039_ARB_RR_EN
  logic r_rr_last;

  ysyx_22050039_arb_pick u_pick (
    .i_if_req  (i_if_req),
    .i_ls_req  (i_ls_req),
    .i_rr_last (r_rr_last),
    .o_win_id  (w_win_id),
    .o_win_vld (w_win_vld)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr_last <= REQ_IF;
    end else if (w_grant) begin
      r_rr_last <= w_win_id;
    end
  end
`else
  ysyx_22050039_arb_pick u_pick (
    .i_if_req  (i_if_req),
    .i_ls_req  (i_ls_req),
    .o_win_id  (w_win_id),
    .o_win_vld (w_win_vld)
  );
`endif

  // Outputs are qualified with rst so the whole port reads 0 while reset is held.
  assign w_grant  = rst && (r_state == IDLE) && w_win_vld;
  assign w_in_mem = rst && ((r_state == S_IF) || (r_state == S_LS));

  assign o_if_gnt    = w_grant && (w_win_id == REQ_IF);
  assign o_ls_gnt    = w_grant && (w_win_id == REQ_LS);
  assign o_if_rvalid = rst && (r_state == RESP) && (r_owner == REQ_IF);
  assign o_ls_rvalid = rst && (r_state == RESP) && (r_owner == REQ_LS);
  assign o_if_rdata  = r_if_rdata;
  assign o_ls_rdata  = r_ls_rdata;

  assign o_mem_req   = w_in_mem;
  assign o_mem_we    = w_in_mem && r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_wmask = w_in_mem ? r_wmask : '0;
  assign o_busy      = rst && (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_owner    <= REQ_IF;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_if_rdata <= '0;
      r_ls_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_win_vld) begin
            r_owner <= w_win_id;
            if (w_win_id == REQ_LS) begin
              r_we    <= i_ls_we;
              r_addr  <= i_ls_addr;
              r_wdata <= i_ls_wdata;
              r_wmask <= i_ls_we ? i_ls_wmask : '0;
              r_state <= S_LS;
            end else begin
              r_we    <= 1'b0;
              r_addr  <= i_if_addr;
              r_wdata <= '0;
              r_wmask <= '0;
              r_state <= S_IF;
            end
          end
        end
        S_IF, S_LS: begin
          if (i_mem_done) begin
            if (r_owner == REQ_IF) begin
              r_if_rdata <= i_mem_rdata;
            end else begin
              r_ls_rdata <= r_we ? '0 : i_mem_rdata;
            end
            r_state <= RESP;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050039_mem_arbiter.sv
// Self-checking bench for the pmem arbiter: memory model plus response scoreboard.
module tb_ysyx_22050039_mem_arbiter;
  import ysyx_22050039_arb_pkg::*;

  localparam int XLEN   = 64;
  localparam int MASK_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_if_req = 1'b0;
  logic [XLEN-1:0]   i_if_addr = '0;
  logic              i_ls_req = 1'b0;
  logic              i_ls_we = 1'b0;
  logic [XLEN-1:0]   i_ls_addr = '0;
  logic [XLEN-1:0]   i_ls_wdata = '0;
  logic [MASK_W-1:0] i_ls_wmask = '0;
  logic              i_mem_done;
  logic [XLEN-1:0]   i_mem_rdata;
  logic              o_if_gnt, o_if_rvalid, o_ls_gnt, o_ls_rvalid;
  logic [XLEN-1:0]   o_if_rdata, o_ls_rdata;
  logic              o_mem_req, o_mem_we, o_busy;
  logic [XLEN-1:0]   o_mem_addr, o_mem_wdata;
  logic [MASK_W-1:0] o_mem_wmask;

  ysyx_22050039_mem_arbiter #(.XLEN(XLEN), .MASK_W(MASK_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .o_if_gnt    (o_if_gnt),
    .o_if_rvalid (o_if_rvalid),
    .o_if_rdata  (o_if_rdata),
    .i_ls_req    (i_ls_req),
    .i_ls_we     (i_ls_we),
    .i_ls_addr   (i_ls_addr),
    .i_ls_wdata  (i_ls_wdata),
    .i_ls_wmask  (i_ls_wmask),
    .o_ls_gnt    (o_ls_gnt),
    .o_ls_rvalid (o_ls_rvalid),
    .o_ls_rdata  (o_ls_rdata),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_wmask (o_mem_wmask),
    .i_mem_done  (i_mem_done),
    .i_mem_rdata (i_mem_rdata),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            id;
    logic [XLEN-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   mem_lat = 1;
  int   m_cnt = 0;
  logic force_done = 1'b0;
  logic s_if_gnt = 1'b0;
  logic s_ls_gnt = 1'b0;

  function automatic logic [XLEN-1:0] mem_fn(input logic [XLEN-1:0] a);
    if (a == 64'h8000_0000) return 64'h0010_0073_0000_0413;
    return {a[31:0] ^ 32'h5a5a_5a5a, ~a[31:0]};
  endfunction

  // Memory model: mem_done in the mem_lat-th cycle of mem_req.
  initial begin
    i_mem_done  = 1'b0;
    i_mem_rdata = '0;
    forever begin
      @(negedge clk);
      #2;
      i_mem_done  = 1'b0;
      i_mem_rdata = 64'hbad0_bad0_bad0_bad0;
      if (o_mem_req) begin
        m_cnt++;
        if (m_cnt >= mem_lat) begin
          i_mem_done  = 1'b1;
          i_mem_rdata = mem_fn(o_mem_addr);
          m_cnt       = 0;
        end
      end else begin
        m_cnt = 0;
        if (force_done) begin
          i_mem_done  = 1'b1;
          i_mem_rdata = 64'hdead_dead_dead_dead;
          force_done  = 1'b0;
        end
      end
    end
  end

  // Requests drop on the negedge after the grant was seen.
  task automatic cyc_begin();
    @(negedge clk);
    if (s_if_gnt) i_if_req = 1'b0;
    if (s_ls_gnt) i_ls_req = 1'b0;
  endtask

  task automatic cyc_end();
    #4;
    s_if_gnt = o_if_gnt;
    s_ls_gnt = o_ls_gnt;
  endtask

  task automatic test_reset();
    logic got = 1'b0;
    exp_t e;
    rst = 1'b0;
    i_if_req = 1'b1;
    i_if_addr = 64'h8000_0100;
    for (int k = 0; k < 2; k++) begin
      cyc_begin();
      cyc_end();
      n_cmp++;
      if ({o_if_gnt, o_if_rvalid, o_if_rdata, o_ls_gnt, o_ls_rvalid, o_ls_rdata, o_mem_req,
           o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask, o_busy} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs cycle %0d: gnt=%b/%b rvalid=%b/%b mem_req=%b busy=%b addr=%h, required all 0",
                 k, o_if_gnt, o_ls_gnt, o_if_rvalid, o_ls_rvalid, o_mem_req, o_busy, o_mem_addr);
      end
    end
    cyc_begin();
    rst = 1'b1;
    sb.push_back('{REQ_IF, mem_fn(64'h8000_0100)});
    cyc_end();
    n_cmp++;
    if (o_if_gnt !== 1'b1 || o_ls_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL reset_first_grant: if_gnt=%b ls_gnt=%b, required 1/0", o_if_gnt, o_ls_gnt);
    end
    for (int k = 0; k < 10 && !got; k++) begin
      cyc_begin();
      cyc_end();
      if (o_if_rvalid || o_ls_rvalid) begin
        got = 1'b1;
        n_cmp++;
        e = sb.pop_front();
        if (o_ls_rvalid !== e.id || o_if_rvalid === o_ls_rvalid || o_if_rdata !== e.data) begin
          n_err++;
          $display("FAIL reset_first_resp: rvalid=%b/%b rdata=%h, required if rdata=%h",
                   o_if_rvalid, o_ls_rvalid, o_if_rdata, e.data);
        end
      end
    end
    if (!got) begin
      n_cmp++; n_err++; sb.delete();
      $display("FAIL reset_first_resp: no rvalid within 10 cycles, required one");
    end
  endtask

  task automatic test_if_fetch();
    int g = -1, m = -1, r = -1;
    exp_t e;
    mem_lat = 1;
    cyc_begin();
    i_if_req = 1'b1;
    i_if_addr = 64'h8000_0000;
    sb.push_back('{REQ_IF, 64'h0010_0073_0000_0413});
    for (int k = 0; k < 10 && r < 0; k++) begin
      if (k > 0) cyc_begin();
      cyc_end();
      if (o_if_gnt && g < 0) g = k;
      if (o_mem_req && m < 0) begin
        m = k;
        n_cmp++;
        if (o_mem_addr !== 64'h8000_0000 || o_mem_we !== 1'b0 || o_mem_wmask !== '0) begin
          n_err++;
          $display("FAIL if_mem_fields: addr=%h we=%b wmask=%h, required 80000000/0/00",
                   o_mem_addr, o_mem_we, o_mem_wmask);
        end
      end
      if (o_if_rvalid || o_ls_rvalid) begin
        r = k;
        n_cmp++;
        e = sb.pop_front();
        if (o_ls_rvalid !== e.id || o_if_rvalid === o_ls_rvalid || o_if_rdata !== e.data) begin
          n_err++;
          $display("FAIL if_rdata: rvalid=%b/%b rdata=%h, required if rdata=%h",
                   o_if_rvalid, o_ls_rvalid, o_if_rdata, e.data);
        end
      end
    end
    n_cmp++;
    if (g < 0 || m != g + 1 || r != g + 2) begin
      n_err++; sb.delete();
      $display("FAIL if_latency: gnt=%0d mem_req=%0d rvalid=%0d, required mem_req=gnt+1 rvalid=gnt+2", g, m, r);
    end
  endtask

  task automatic test_ls_store();
    int n_mreq = 0;
    logic bad = 1'b0;
    logic got = 1'b0;
    exp_t e;
    mem_lat = 3;
    cyc_begin();
    i_ls_req = 1'b1; i_ls_we = 1'b1; i_ls_addr = 64'h8000_1008;
    i_ls_wdata = 64'h0000_0000_dead_beef; i_ls_wmask = 8'h0f;
    sb.push_back('{REQ_LS, 64'h0});
    for (int k = 0; k < 12 && !got; k++) begin
      if (k > 0) cyc_begin();
      cyc_end();
      if (o_mem_req) begin
        n_mreq++;
        if (o_mem_we !== 1'b1 || o_mem_wmask !== 8'h0f || o_mem_addr !== 64'h8000_1008 ||
            o_mem_wdata !== 64'h0000_0000_dead_beef) bad = 1'b1;
      end
      if (o_if_rvalid || o_ls_rvalid) begin
        got = 1'b1;
        n_cmp++;
        e = sb.pop_front();
        if (o_ls_rvalid !== e.id || o_if_rvalid === o_ls_rvalid || o_ls_rdata !== e.data) begin
          n_err++;
          $display("FAIL ls_store_ack: rvalid=%b/%b ls_rdata=%h, required ls ack rdata=%h",
                   o_if_rvalid, o_ls_rvalid, o_ls_rdata, e.data);
        end
      end
    end
    i_ls_we = 1'b0;
    n_cmp++;
    if (n_mreq != 3 || bad || !got) begin
      n_err++; sb.delete();
      $display("FAIL ls_store_hold: mem_req cycles=%0d bad_fields=%b ack=%b, required 3/0/1", n_mreq, bad, got);
    end
  endtask

  task automatic test_arbitration();
    logic exp_seq [5];
    int   n_g = 0;
    exp_t e;
`ifdef YSYX_22050039_ARB_RR_EN
    exp_seq = '{REQ_LS, REQ_IF, REQ_LS, REQ_IF, REQ_LS};
`else
    exp_seq = '{REQ_LS, REQ_LS, REQ_LS, REQ_LS, REQ_IF};
`endif
    mem_lat = 1;
    cyc_begin();
    rst = 1'b0;
    cyc_end();
    cyc_begin();
    rst = 1'b1;
    i_if_req = 1'b1; i_if_addr = 64'h8000_2000;
    i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 64'h8000_3000; i_ls_wmask = '0;
    for (int k = 0; k < 60 && !(n_g == 5 && sb.size() == 0); k++) begin
      if (k > 0) begin
        cyc_begin();
        if (s_if_gnt && n_g < 4) begin i_if_req = 1'b1; i_if_addr = 64'h8000_2000 + 64'(8 * n_g); end
        if (s_ls_gnt && n_g < 4) begin i_ls_req = 1'b1; i_ls_addr = 64'h8000_3000 + 64'(8 * n_g); end
      end
      cyc_end();
      if (o_if_gnt || o_ls_gnt) begin
        n_cmp++;
        if (n_g >= 5 || (o_if_gnt && o_ls_gnt) || o_ls_gnt !== exp_seq[n_g]) begin
          n_err++;
          $display("FAIL arb_order grant %0d: if_gnt=%b ls_gnt=%b, required ls_gnt=%b",
                   n_g, o_if_gnt, o_ls_gnt, (n_g < 5) ? exp_seq[n_g] : 1'bx);
        end
        sb.push_back('{o_ls_gnt, mem_fn(o_ls_gnt ? i_ls_addr : i_if_addr)});
        n_g++;
      end
      if (o_if_rvalid || o_ls_rvalid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL arb_resp: rvalid=%b/%b with nothing outstanding, required none", o_if_rvalid, o_ls_rvalid);
        end else begin
          e = sb.pop_front();
          if (o_ls_rvalid !== e.id || o_if_rvalid === o_ls_rvalid ||
              (e.id ? o_ls_rdata : o_if_rdata) !== e.data) begin
            n_err++;
            $display("FAIL arb_resp: rvalid=%b/%b rdata=%h/%h, required id=%b rdata=%h",
                     o_if_rvalid, o_ls_rvalid, o_if_rdata, o_ls_rdata, e.id, e.data);
          end
        end
      end
    end
    n_cmp++;
    if (n_g != 5 || sb.size() != 0) begin
      n_err++;
      $display("FAIL arb_count: grants=%0d outstanding=%0d, required 5/0", n_g, sb.size());
      sb.delete();
    end
    i_if_req = 1'b0; i_ls_req = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    logic seen = 1'b0;
    logic bad = 1'b0;
    mem_lat = 6;
    cyc_begin();
    i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 64'h8000_4000;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (k > 0) cyc_begin();
      cyc_end();
      if (o_mem_req) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL rstmid_start: mem_req never rose, required 1");
    end
    cyc_begin(); rst = 1'b0; cyc_end();
    cyc_begin(); rst = 1'b1; cyc_end();
    n_cmp++;
    if (o_mem_req !== 1'b0 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_abort: mem_req=%b busy=%b, required 0/0", o_mem_req, o_busy);
    end
    for (int k = 0; k < 8; k++) begin
      cyc_begin();
      if (k == 2) force_done = 1'b1;
      cyc_end();
      if (o_if_rvalid || o_ls_rvalid || o_busy) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL rstmid_no_rvalid: rvalid or busy seen after abort, required none");
    end
    n_cmp++;
    if (o_ls_rdata !== '0) begin
      n_err++;
      $display("FAIL rstmid_rdata: ls_rdata=%h, required 0", o_ls_rdata);
    end
  endtask

  task automatic test_spurious_done();
    int   g = -1, r = -1, lg = -1;
    logic ls_up = 1'b0, saw_busy = 1'b0, bad = 1'b0, got_ls = 1'b0;
    exp_t e;
    mem_lat = 3;
    cyc_begin(); force_done = 1'b1; cyc_end();
    cyc_begin(); cyc_end();
    n_cmp++;
    if (o_if_rvalid || o_ls_rvalid || o_busy) begin
      n_err++;
      $display("FAIL idle_done_ignored: rvalid=%b/%b busy=%b, required 0/0/0", o_if_rvalid, o_ls_rvalid, o_busy);
    end
    cyc_begin();
    i_if_req = 1'b1; i_if_addr = 64'h8000_5000;
    sb.push_back('{REQ_IF, mem_fn(64'h8000_5000)});
    for (int k = 0; k < 20 && !got_ls; k++) begin
      if (k > 0) begin
        cyc_begin();
        if (saw_busy && !ls_up) begin
          ls_up = 1'b1;
          i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 64'h8000_5008;
          sb.push_back('{REQ_LS, mem_fn(64'h8000_5008)});
        end
      end
      cyc_end();
      if (o_busy) saw_busy = 1'b1;
      if ((o_if_gnt && !i_if_req) || (o_ls_gnt && !i_ls_req)) bad = 1'b1;
      if (o_if_gnt && g < 0) g = k;
      if (o_ls_gnt && lg < 0) lg = k;
      if (o_if_rvalid || o_ls_rvalid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL wait_resp: rvalid=%b/%b with nothing outstanding, required none", o_if_rvalid, o_ls_rvalid);
        end else begin
          e = sb.pop_front();
          if (o_ls_rvalid !== e.id || o_if_rvalid === o_ls_rvalid ||
              (e.id ? o_ls_rdata : o_if_rdata) !== e.data) begin
            n_err++;
            $display("FAIL wait_resp: rvalid=%b/%b rdata=%h/%h, required id=%b rdata=%h",
                     o_if_rvalid, o_ls_rvalid, o_if_rdata, o_ls_rdata, e.id, e.data);
          end
          if (e.id == REQ_IF) r = k;
          else got_ls = 1'b1;
        end
      end
    end
    n_cmp++;
    if (g < 0 || r < 0 || lg != r + 1 || !got_ls || bad) begin
      n_err++;
      $display("FAIL wait_grant: if_gnt=%0d if_rvalid=%0d ls_gnt=%0d ls_done=%b gnt_wo_req=%b, required ls_gnt=if_rvalid+1",
               g, r, lg, got_ls, bad);
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_ls_store();
    test_arbitration();
    test_reset_mid_access();
    test_spurious_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
